// File: rtl/dmem_port_arbiter.sv
// Two-master round-robin arbiter for the MIPS16 single-port data memory.
// Master 0 is the CPU data port, master 1 the debug/loader port. Supports a
// lock for atomic read-modify-write and routes one-cycle read data back to
// the master that issued the read.
module dmem_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          m0_req_i,
    input  logic          m1_req_i,
    input  logic          m0_we_i,
    input  logic          m1_we_i,
    input  logic          m0_lock_i,
    input  logic          m1_lock_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m0_gnt_o,
    output logic          m1_gnt_o,
    output logic          m0_rvalid_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    // Arbitration state: last winner, lock ownership, pending read return.
    logic last_q,       last_d;
    logic locked_q,     locked_d;
    logic lock_owner_q, lock_owner_d;
    logic rd_pend_q,    rd_pend_d;
    logic rd_tag_q,     rd_tag_d;

    // Grant decision for the current cycle.
    logic gnt_valid;
    logic gnt_sel;

    // Request/lock of whichever master currently owns the lock.
    logic owner_req;
    logic owner_lock;

    // Fields of the granted master.
    logic          sel_we;
    logic          sel_lock;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign owner_req  = lock_owner_q ? m1_req_i  : m0_req_i;
    assign owner_lock = lock_owner_q ? m1_lock_i : m0_lock_i;

    assign sel_we    = gnt_sel ? m1_we_i    : m0_we_i;
    assign sel_lock  = gnt_sel ? m1_lock_i  : m0_lock_i;
    assign sel_addr  = gnt_sel ? m1_addr_i  : m0_addr_i;
    assign sel_wdata = gnt_sel ? m1_wdata_i : m0_wdata_i;

    // Pick the winner: lock owner only while locked, otherwise round-robin.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        gnt_valid = 1'b0;
        gnt_sel   = 1'b0;
        if (locked_q) begin
            if (owner_req) begin
                gnt_valid = 1'b1;
                gnt_sel   = lock_owner_q;
            end
        end else if (m0_req_i && m1_req_i) begin
            gnt_valid = 1'b1;
            gnt_sel   = ~last_q;
        end else if (m0_req_i) begin
            gnt_valid = 1'b1;
            gnt_sel   = 1'b0;
        end else if (m1_req_i) begin
            gnt_valid = 1'b1;
            gnt_sel   = 1'b1;
        end
    end

    assign m0_gnt_o = gnt_valid & ~gnt_sel;
    assign m1_gnt_o = gnt_valid &  gnt_sel;

    // Memory strobes are only ever driven by a grant; idle bus is all zero.
    assign mem_en_o    = gnt_valid;
    assign mem_we_o    = gnt_valid & sel_we;
    assign mem_addr_o  = gnt_valid ? sel_addr  : '0;
    assign mem_wdata_o = gnt_valid ? sel_wdata : '0;

    // Next-state: record winner, update lock, queue the read return.
    always_comb begin
        last_d       = last_q;
        locked_d     = locked_q;
        lock_owner_d = lock_owner_q;
        rd_pend_d    = 1'b0;
        rd_tag_d     = rd_tag_q;
        if (gnt_valid) begin
            last_d       = gnt_sel;
            locked_d     = sel_lock;
            lock_owner_d = gnt_sel;
            rd_pend_d    = ~sel_we;
            rd_tag_d     = gnt_sel;
        end else if (locked_q && !owner_req && !owner_lock) begin
            // Owner walked away without finishing its sequence.
            locked_d = 1'b0;
        end
    end

    // State register; reset makes master 0 win the first contention.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            last_q       <= 1'b1;
            locked_q     <= 1'b0;
            lock_owner_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_tag_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            last_q       <= last_d;
            locked_q     <= locked_d;
            lock_owner_q <= lock_owner_d;
            rd_pend_q    <= rd_pend_d;
            rd_tag_q     <= rd_tag_d;
        end
    end

    // Read return goes only to the tagged master; the other sees zeros.
    assign m0_rvalid_o = rd_pend_q & ~rd_tag_q;
    assign m1_rvalid_o = rd_pend_q &  rd_tag_q;
    assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference.
module tb_dmem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Master-side stimulus, indexed by master number.
    logic          req   [2];
    logic          we    [2];
    logic          lock  [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    dmem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .m0_req_i    (req[0]),
        .m1_req_i    (req[1]),
        .m0_we_i     (we[0]),
        .m1_we_i     (we[1]),
        .m0_lock_i   (lock[0]),
        .m1_lock_i   (lock[1]),
        .m0_addr_i   (addr[0]),
        .m1_addr_i   (addr[1]),
        .m0_wdata_i  (wdata[0]),
        .m1_wdata_i  (wdata[1]),
        .m0_gnt_o    (m0_gnt),
        .m1_gnt_o    (m1_gnt),
        .m0_rvalid_o (m0_rvalid),
        .m1_rvalid_o (m1_rvalid),
        .m0_rdata_o  (m0_rdata),
        .m1_rdata_o  (m1_rdata),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(int a);
        return 16'(a * 257) ^ 16'hA5C3;
    endfunction

    // Write-first synchronous memory macro; preloaded on the first edge.
    logic [DW-1:0] mem [256];
    logic          mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
        end
    end

    // Reference model: what memory should contain and who is owed what.
    logic [DW-1:0] ref_mem [256];
    int            last_m;
    int            owner;      // -1 when nobody holds the lock
    int            pend_tag;   // -1 when no read return is due
    logic [DW-1:0] pend_data;

    // Values observed in the most recent cycle, for directed checks.
    logic          s_gnt [2];
    logic          s_rv0, s_rv1;
    logic [DW-1:0] s_rd0;
    logic [AW-1:0] s_addr;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        last_m   = 1;
        owner    = -1;
        pend_tag = -1;
    endtask

    task automatic drive(int m, logic r, logic w, logic l, logic [AW-1:0] a, logic [DW-1:0] d);
        req[m]   = r;
        we[m]    = w;
        lock[m]  = l;
        addr[m]  = a;
        wdata[m] = d;
    endtask

    task automatic idle(int m);
        drive(m, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // One clock: check outputs against the model mid-cycle, then advance it.
    task automatic cycle();
        int g;
        #3;
        if (owner >= 0)             g = req[owner] ? owner : -1;
        else if (req[0] && req[1])  g = 1 - last_m;
        else if (req[0])            g = 0;
        else if (req[1])            g = 1;
        else                        g = -1;

        check("gnt", 32'({m1_gnt, m0_gnt}), 32'((g == 1) ? 2'b10 : (g == 0) ? 2'b01 : 2'b00));
        check("mem_en", 32'(mem_en), 32'(g >= 0));
        if (g >= 0) begin
            check("mem_we", 32'(mem_we), 32'(we[g]));
            check("mem_addr", 32'(mem_addr), 32'(addr[g]));
            if (we[g]) check("mem_wdata", 32'(mem_wdata), 32'(wdata[g]));
        end else if (!req[0] && !req[1]) begin
            check("idle_bus", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
        end
        check("rvalid", 32'({m1_rvalid, m0_rvalid}),
              32'((pend_tag == 1) ? 2'b10 : (pend_tag == 0) ? 2'b01 : 2'b00));
        check("rdata0", 32'(m0_rdata), 32'((pend_tag == 0) ? pend_data : 16'h0));
        check("rdata1", 32'(m1_rdata), 32'((pend_tag == 1) ? pend_data : 16'h0));

        s_gnt[0] = m0_gnt;
        s_gnt[1] = m1_gnt;
        s_rv0    = m0_rvalid;
        s_rv1    = m1_rvalid;
        s_rd0    = m0_rdata;
        s_addr   = mem_addr;

        @(posedge clk);
        if (reset_n) begin
            pend_tag = -1;
            if (g >= 0) begin
                last_m = g;
                owner  = lock[g] ? g : -1;
                if (we[g]) begin
                    ref_mem[addr[g]] = wdata[g];
                end else begin
                    pend_tag  = g;
                    pend_data = ref_mem[addr[g]];
                end
            end else if (owner >= 0 && !req[owner] && !lock[owner]) begin
                owner = -1;
            end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        model_reset();
        idle(0);
        idle(1);
        reset_n = 1'b0;

        // Reset: grant is combinational even while reset is held.
        drive(0, 1'b1, 1'b0, 1'b0, 8'h05, 16'h0);
        cycle();
        check("rst_m0_gnt", 32'(s_gnt[0]), 32'd1);
        check("rst_m0_rvalid", 32'(s_rv0), 32'd0);
        reset_n = 1'b1;
        cycle();
        idle(0);
        cycle();
        check("rst_read_rvalid", 32'(s_rv0), 32'd1);
        check("rst_read_data", 32'(s_rd0), 32'(init_val(5)));

        // Reset pulse right after a granted read drops the return.
        drive(0, 1'b1, 1'b0, 1'b0, 8'h21, 16'h0);
        cycle();
        idle(0);
        reset_n = 1'b0;
        model_reset();
        cycle();
        check("midrst_rvalid", 32'(s_rv0), 32'd0);
        check("midrst_rdata", 32'(s_rd0), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("midrst_after_rvalid", 32'(s_rv0), 32'd0);
        end

        // Contention: alternating grants starting with master 0.
        drive(0, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 8'h20, 16'h0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("cont_gnt0", 32'(s_gnt[0]), 32'(i % 2 == 0));
            check("cont_addr", 32'(s_addr), (i % 2 == 0) ? 32'h10 : 32'h20);
        end
        idle(0);
        idle(1);
        cycle();

        // Write by master 1 then read-back by master 0.
        drive(1, 1'b1, 1'b1, 1'b0, 8'h3A, 16'hBEEF);
        cycle();
        check("wr_no_rv1_a", 32'(s_rv1), 32'd0);
        idle(1);
        drive(0, 1'b1, 1'b0, 1'b0, 8'h3A, 16'h0);
        cycle();
        check("wr_no_rv1_b", 32'(s_rv1), 32'd0);
        idle(0);
        cycle();
        check("wr_rd_data", 32'(s_rd0), 32'hBEEF);
        check("wr_no_rv1_c", 32'(s_rv1), 32'd0);

        // Locked read-modify-write by master 1 while master 0 waits.
        drive(1, 1'b1, 1'b0, 1'b1, 8'h07, 16'h0);
        drive(0, 1'b1, 1'b0, 1'b0, 8'h44, 16'h0);
        cycle();
        check("rmw_rd_gnt1", 32'(s_gnt[1]), 32'd1);
        check("rmw_rd_gnt0", 32'(s_gnt[0]), 32'd0);
        drive(1, 1'b1, 1'b1, 1'b0, 8'h07, 16'h1234);
        cycle();
        check("rmw_wr_gnt1", 32'(s_gnt[1]), 32'd1);
        check("rmw_wr_gnt0", 32'(s_gnt[0]), 32'd0);
        idle(1);
        cycle();
        check("rmw_after_gnt0", 32'(s_gnt[0]), 32'd1);
        idle(0);
        cycle();

        // Abandoned lock: owner leaves, the waiter gets in after release.
        drive(0, 1'b1, 1'b0, 1'b1, 8'h08, 16'h0);
        cycle();
        check("abandon_lock_gnt0", 32'(s_gnt[0]), 32'd1);
        idle(0);
        drive(1, 1'b1, 1'b0, 1'b0, 8'h09, 16'h0);
        cycle();
        check("abandon_wait_gnt1", 32'(s_gnt[1]), 32'd0);
        cycle();
        check("abandon_gnt1", 32'(s_gnt[1]), 32'd1);
        idle(1);
        cycle();

        // Random traffic: each master holds a request until granted.
        for (int n = 0; n < 3000; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (!req[m] || s_gnt[m]) begin
                    if ($urandom_range(3) == 0)
                        idle(m);
                    else
                        drive(m, 1'b1, 1'($urandom_range(1)), ($urandom_range(3) == 0),
                              8'($urandom_range(15)), 16'($urandom));
                end
            end
            cycle();
        end
        idle(0);
        idle(1);
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
